// File: rtl/w5300_host_bus_if.sv
// w5300_host_bus_if
//   Turns one register access request into a timed W5300 direct-address
//   16-bit host-bus cycle: address/data setup, /CS + /RD or /WR strobe,
//   then address/data hold. Read data is captured on the edge that ends
//   the strobe.
//
//   Optional build macro: W5300_BUS_RECOVERY_EN adds a RECOVER state
//   after HOLD. /CS stays high for RECOVERY_CYC clocks, and op_state
//   stays low until that gap has elapsed.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   req            access request, sampled only while op_state=1
//   addr[10:0]     [10] = 1 write / 0 read, [9:0] = register address
//   wr_data[15:0]  write data
//   rd_data[15:0]  last captured read data
//   op_state       1 = idle/ready, 0 = access in progress
//   w5300_addr     chip address bus
//   w5300_cs_n     chip select, active low
//   w5300_rd_n     read strobe, active low
//   w5300_wr_n     write strobe, active low
//   w5300_data_o   data to chip
//   w5300_data_oe  1 = FPGA drives the data bus
//   w5300_data_i   data from chip
module w5300_host_bus_if #(
  parameter int unsigned ADDR_SETUP_CYC = 2,
  parameter int unsigned STROBE_CYC     = 17,
  parameter int unsigned HOLD_CYC       = 2,
  parameter int unsigned RECOVERY_CYC   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [10:0] addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        op_state,
  output logic [9:0]  w5300_addr,
  output logic        w5300_cs_n,
  output logic        w5300_rd_n,
  output logic        w5300_wr_n,
  output logic [15:0] w5300_data_o,
  output logic        w5300_data_oe,
  input  logic [15:0] w5300_data_i
);

  localparam int unsigned MAX_A   = (ADDR_SETUP_CYC > STROBE_CYC) ? ADDR_SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_B   = (HOLD_CYC > RECOVERY_CYC) ? HOLD_CYC : RECOVERY_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  if (ADDR_SETUP_CYC < 1) begin : g_bad_setup
    $error("ADDR_SETUP_CYC must be >= 1");
  end
  if (STROBE_CYC < 1) begin : g_bad_strobe
    $error("STROBE_CYC must be >= 1");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("HOLD_CYC must be >= 1");
  end
  if (RECOVERY_CYC < 1) begin : g_bad_recovery
    $error("RECOVERY_CYC must be >= 1");
  end

`ifdef W5300_BUS_RECOVERY_EN
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;

  logic [15:0]        rd_data_d;
  logic               op_state_d;
  logic [9:0]         addr_d;
  logic               cs_n_d, rd_n_d, wr_n_d;
  logic [15:0]        data_o_d;
  logic               oe_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dir_q         <= 1'b0;
      rd_data       <= '0;
      op_state      <= 1'b1;
      w5300_addr    <= '0;
      w5300_cs_n    <= 1'b1;
      w5300_rd_n    <= 1'b1;
      w5300_wr_n    <= 1'b1;
      w5300_data_o  <= '0;
      w5300_data_oe <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dir_q         <= dir_d;
      rd_data       <= rd_data_d;
      op_state      <= op_state_d;
      w5300_addr    <= addr_d;
      w5300_cs_n    <= cs_n_d;
      w5300_rd_n    <= rd_n_d;
      w5300_wr_n    <= wr_n_d;
      w5300_data_o  <= data_o_d;
      w5300_data_oe <= oe_d;
    end
  end

  // Every output is registered, so the next-state logic also computes the
  // next value of each pin; strobe edges land on the state-change edges.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    dir_d      = dir_q;
    rd_data_d  = rd_data;
    op_state_d = op_state;
    addr_d     = w5300_addr;
    cs_n_d     = w5300_cs_n;
    rd_n_d     = w5300_rd_n;
    wr_n_d     = w5300_wr_n;
    data_o_d   = w5300_data_o;
    oe_d       = w5300_data_oe;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req) begin
          addr_d     = addr[9:0];
          data_o_d   = wr_data;
          dir_d      = addr[10];
          oe_d       = addr[10];
          op_state_d = 1'b0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(ADDR_SETUP_CYC - 1)) begin
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          wr_n_d  = !dir_q;
          rd_n_d  = dir_q;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (cnt_q == CNT_W'(STROBE_CYC - 1)) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          rd_n_d  = 1'b1;
          if (!dir_q) begin
            rd_data_d = w5300_data_i;
          end
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          cnt_d = '0;
          oe_d  = 1'b0;
`ifdef W5300_BUS_RECOVERY_EN
          state_d = RECOVER;
`else
          op_state_d = 1'b1;
          state_d    = IDLE;
`endif
        end
      end
`ifdef W5300_BUS_RECOVERY_EN
      RECOVER: begin
        if (cnt_q == CNT_W'(RECOVERY_CYC - 1)) begin
          cnt_d      = '0;
          op_state_d = 1'b1;
          state_d    = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_w5300_host_bus_if.sv
// tb_w5300_host_bus_if
//   Self-checking bench for w5300_host_bus_if: a table of directed accesses,
//   back-to-back and busy-request sequences, reset during a read strobe, and
//   a randomized access stream checked against a per-access reference model
//   (expected strobe/oe/busy durations and the last-read-data value).
//   Honours W5300_BUS_RECOVERY_EN for the expected access latency.
module tb_w5300_host_bus_if;

  localparam int unsigned SU = 2;
  localparam int unsigned ST = 17;
  localparam int unsigned HO = 2;
  localparam int unsigned RC = 7;
`ifdef W5300_BUS_RECOVERY_EN
  localparam int unsigned LAT = SU + ST + HO + RC;
`else
  localparam int unsigned LAT = SU + ST + HO;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [10:0] addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] w5300_data_i = '0;
  logic [15:0] rd_data;
  logic        op_state;
  logic [9:0]  w5300_addr;
  logic        w5300_cs_n, w5300_rd_n, w5300_wr_n;
  logic [15:0] w5300_data_o;
  logic        w5300_data_oe;

  w5300_host_bus_if #(
    .ADDR_SETUP_CYC (SU),
    .STROBE_CYC     (ST),
    .HOLD_CYC       (HO),
    .RECOVERY_CYC   (RC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .addr          (addr),
    .wr_data       (wr_data),
    .rd_data       (rd_data),
    .op_state      (op_state),
    .w5300_addr    (w5300_addr),
    .w5300_cs_n    (w5300_cs_n),
    .w5300_rd_n    (w5300_rd_n),
    .w5300_wr_n    (w5300_wr_n),
    .w5300_data_o  (w5300_data_o),
    .w5300_data_oe (w5300_data_oe),
    .w5300_data_i  (w5300_data_i)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] model_rd = '0;

  typedef struct {
    logic        wr;
    logic [9:0]  a;
    logic [15:0] wd;
    logic [15:0] di;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller must be at a negedge; the request is presented immediately.
  task automatic access(input logic wr, input logic [9:0] a, input logic [15:0] wd,
                        input logic [15:0] di, input bit keep_req);
    int unsigned busy = 0;
    int unsigned wr_low = 0;
    int unsigned rd_low = 0;
    int unsigned oe_hi = 0;
    int unsigned first_low = 999;
    int unsigned bad = 0;
    req = 1'b1;
    addr = {wr, a};
    wr_data = wd;
    w5300_data_i = ~di;
    @(posedge clk);
    #1;
    check("accept", 32'(op_state), 32'd0);
    // Inputs are scrambled while busy; the DUT must ignore them.
    req = 1'($urandom_range(0, 1));
    addr = 11'($urandom);
    wr_data = 16'($urandom);
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (op_state) break;
      busy++;
      if (!w5300_wr_n) wr_low++;
      if (!w5300_rd_n) rd_low++;
      if (w5300_data_oe) oe_hi++;
      if ((!w5300_wr_n || !w5300_rd_n) && first_low == 999) first_low = n;
      if (w5300_addr !== a || w5300_data_o !== wd) bad++;
      if (!w5300_wr_n && !w5300_rd_n) bad++;
      if (w5300_cs_n !== (w5300_rd_n & w5300_wr_n)) bad++;
      w5300_data_i = w5300_rd_n ? ~di : di;
      req = 1'($urandom_range(0, 1));
      addr = 11'($urandom);
    end
    req = keep_req ? 1'b1 : 1'b0;
    if (!wr) model_rd = di;
    check("busy_len", busy, LAT);
    check("wr_low", wr_low, wr ? ST : 0);
    check("rd_low", rd_low, wr ? 0 : ST);
    check("oe_high", oe_hi, wr ? SU + ST + HO : 0);
    check("strobe_start", first_low, SU);
    check("bus_integrity", bad, 0);
    check("rd_data", 32'(rd_data), 32'(model_rd));
    check("addr_kept", 32'(w5300_addr), 32'(a));
  endtask

  task automatic idle_check(input int unsigned n);
    req = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      @(negedge clk);
      check("idle_pins", 32'({op_state, w5300_cs_n, w5300_rd_n, w5300_wr_n, w5300_data_oe}), 32'b11110);
      check("idle_rd_data", 32'(rd_data), 32'(model_rd));
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 10'h208, 16'h0001, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 10'h208, 16'h0000, 16'h0013, 16'h0013};
    tbl[2] = '{1'b1, 10'h3FF, 16'hFFFF, 16'h0000, 16'h0013};
    tbl[3] = '{1'b0, 10'h000, 16'h1234, 16'h0014, 16'h0014};
    tbl[4] = '{1'b0, 10'h3FF, 16'h0000, 16'hA5A5, 16'hA5A5};
    tbl[5] = '{1'b1, 10'h000, 16'h0000, 16'hFFFF, 16'hA5A5};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_pins", 32'({op_state, w5300_cs_n, w5300_rd_n, w5300_wr_n, w5300_data_oe}), 32'b11110);
    check("rst_addr", 32'(w5300_addr), 32'd0);
    check("rst_data_o", 32'(w5300_data_o), 32'd0);
    rst_n = 1'b1;
    idle_check(2);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      access(tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].di, 1'b0);
      check("tbl_rd_data", 32'(rd_data), 32'(tbl[i].exp_rd));
      idle_check(1);
    end

    // Back-to-back: read with req held, then write; read data survives
    access(1'b0, 10'h208, 16'h0000, 16'h0014, 1'b1);
    access(1'b1, 10'h208, 16'h55AA, 16'h0000, 1'b0);
    check("b2b_rd_kept", 32'(rd_data), 32'h0014);
    idle_check(3);

    // Reset in the middle of a read strobe
    req = 1'b1;
    addr = {1'b0, 10'h1AB};
    w5300_data_i = 16'h7777;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_strobe_rd_n", 32'(w5300_rd_n), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pins", 32'({op_state, w5300_cs_n, w5300_rd_n, w5300_wr_n, w5300_data_oe}), 32'b11110);
    check("arst_rd_data", 32'(rd_data), 32'd0);
    model_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(2);
    access(1'b0, 10'h208, 16'h0000, 16'h0BAD, 1'b0);
    idle_check(2);

    // Randomized stream against the reference model
    for (int k = 0; k < 40; k++) begin
      logic        wr;
      logic [9:0]  a;
      logic [15:0] wd;
      logic [15:0] di;
      bit          keep;
      wr   = 1'($urandom_range(0, 1));
      a    = 10'($urandom);
      wd   = 16'($urandom);
      di   = 16'($urandom);
      keep = (k < 39) ? bit'($urandom_range(0, 1)) : 1'b0;
      access(wr, a, wd, di, keep);
      if (!keep) idle_check($urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/w5300_host_bus_if.md
Name: w5300_host_bus_if

Overview:
- Downstream stage of the socket/common configuration blocks.
- Converts one register access (11-bit addr with wr_rd_flag MSB, wr_data) into a timed W5300 direct-address 16-bit host-bus cycle.
- Drives /CS, /RD, /WR, ADDR[9:0] and the data bus; returns captured read data.
- Reports idle/ready through op_state.

Parameters:
- ADDR_SETUP_CYC, 2, clocks ADDR/DATA are stable before /CS and strobe fall (min 1).
- STROBE_CYC, 17, clocks /CS plus /RD or /WR are held low (min 1; 17 x 4 ns >= 65 ns).
- HOLD_CYC, 2, clocks ADDR/DATA are held after strobes rise (min 1).
- RECOVERY_CYC, 7, minimum /CS-high gap between accesses; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- req  in  1  access request, sampled only when op_state=1.
- addr  in  11  [10] = wr_rd_flag (1 = write, 0 = read); [9:0] = W5300 register address.
- wr_data  in  16  write data.
- rd_data  out  16  last captured read data.
- op_state  out  1  1 = idle/ready; 0 = access in progress.
- w5300_addr  out  10  chip address bus.
- w5300_cs_n  out  1  chip select, active low.
- w5300_rd_n  out  1  read strobe, active low.
- w5300_wr_n  out  1  write strobe, active low.
- w5300_data_o  out  16  data to chip.
- w5300_data_oe  out  1  1 = FPGA drives data bus (tristate handled at top level).
- w5300_data_i  in  16  data from chip.

Behaviour:
- Reset (async, immediate): rd_data=0, op_state=1, w5300_cs_n/rd_n/wr_n=1, w5300_data_oe=0, w5300_addr=0, w5300_data_o=0, state IDLE, counter 0.
- All outputs are registered.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - On a clock edge with req=1, latch addr[9:0] -> w5300_addr, wr_data -> w5300_data_o and the direction bit.
  - Set op_state=0, set w5300_data_oe=direction, go to SETUP.
  - req=0: stay in IDLE, outputs unchanged.
- SETUP:
  - Strobes high; lasts exactly ADDR_SETUP_CYC clocks, then STROBE.
  - On entering STROBE: w5300_cs_n=0, plus w5300_wr_n=0 (write) or w5300_rd_n=0 (read).
- STROBE:
  - Strobes low for exactly STROBE_CYC clocks.
  - Read: on the edge that ends STROBE, capture w5300_data_i into rd_data.
  - On that same edge, all strobes return high.
- HOLD:
  - w5300_addr, w5300_data_o and w5300_data_oe are unchanged for HOLD_CYC clocks.
  - On exit: w5300_data_oe=0, op_state=1, state IDLE.
- Latency: op_state is low for ADDR_SETUP_CYC+STROBE_CYC+HOLD_CYC clocks; 21 clocks at defaults.
- rd_data is valid when op_state rises.
- rd_data is unchanged by writes and holds its value until the next read.
- Back-to-back: req=1 on the op_state-rising cycle is accepted on the next edge (one IDLE clock minimum, no recovery gap).
- req while busy: ignored; no queue. addr/wr_data changes during an access have no effect.
- w5300_rd_n and w5300_wr_n are never low together.
- w5300_cs_n is low exactly when one strobe is low.
- Reset mid-access: strobes deassert and oe drops asynchronously; no partial capture into rd_data.
- Counter width is $clog2 of the largest cycle parameter plus 1.
- Elaboration error if any cycle parameter is < 1.

Optional Feature:
- Macro: W5300_BUS_RECOVERY_EN.
- Defined:
  - Adds state RECOVER after HOLD.
  - w5300_cs_n stays high for RECOVERY_CYC clocks; op_state stays 0 during RECOVER, then goes 1 in IDLE.
  - Access latency becomes SETUP+STROBE+HOLD+RECOVERY.
- Undefined: no RECOVER state; behaviour as above.

Test Plan:
- Write, defaults: req=1, addr={1'b1,10'h208}, wr_data=16'h0001 -> w5300_addr=10'h208, w5300_wr_n low exactly 17 clocks, w5300_rd_n always 1, w5300_data_oe high 21 clocks, op_state low 21 clocks.
- Read: addr={1'b0,10'h208}, w5300_data_i=16'h0013 during STROBE -> w5300_rd_n low 17 clocks, w5300_data_oe=0 throughout, rd_data=16'h0013 when op_state rises.
- Back-to-back: read (data_i=16'h0014) with req held high, then write -> second access starts 1 clock after op_state rises; rd_data=16'h0014 preserved through the write.
- Busy req: pulse req with a different addr during STROBE -> ignored; only one cycle on the bus, w5300_addr unchanged.
- Reset mid-STROBE of a read: rst_n=0 -> w5300_cs_n/rd_n=1, oe=0, op_state=1 immediately; rd_data=0; next req completes normally.
- W5300_BUS_RECOVERY_EN defined, two back-to-back accesses -> w5300_cs_n high >= 7 clocks between them; op_state low 28 clocks per access.
